mux2_pipe: RTL and testbench

- 2:1 selector. `out` follows `in1` when `sel`=0 and `in2` when `sel`=1, combinationally.
- Also provides a registered copy of the selected data with a valid flag, plus a saturating counter of select toggles for debug.
- Leaf datapath block, used wherever one of two buses is steered into a downstream stage.

---
 rtl/mux2_pipe_pkg.sv | 10 +
 rtl/mux2_core.sv | 16 +
 rtl/mux2_pipe.sv | 73 +++++++
 tb/tb_mux2_pipe.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mux2_pipe_pkg.sv
// rtl/mux2_pipe_pkg.sv - shared defaults and select encodings for mux2_pipe
package mux2_pipe_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 8;

    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

endpackage

// File: rtl/mux2_core.sv
// rtl/mux2_core.sv - combinational WIDTH-bit 2:1 select
module mux2_core
    import mux2_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out
);

    // Steer in2 through when sel picks it, otherwise in1
    assign out = (sel == SEL_IN2) ? in2 : in1;

endmodule

// File: rtl/mux2_pipe.sv
// rtl/mux2_pipe.sv - 2:1 select with registered copy and sel toggle counter; option MUX2_PIPE_OUT_REG_EN registers out
module mux2_pipe
    import mux2_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_q_valid,
    output logic [CNT_W-1:0] sel_toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] mux_out;
    logic             sel_prev;

    mux2_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .sel (sel),
        .in1 (in1),
        .in2 (in2),
        .out (mux_out)
    );

`ifdef MUX2_PIPE_OUT_REG_EN
    // Registered out: one cycle behind the inputs, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= mux_out;
        end
    end
`else
    assign out = mux_out;
`endif

    // Capture the selection when qualified; valid mirrors in_valid one cycle late
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_q_valid <= 1'b0;
        end else begin
            out_q_valid <= in_valid;
            if (in_valid) begin
                out_q <= mux_out;
            end
        end
    end

    // Count sel transitions against last cycle's sel, stopping at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_prev       <= SEL_IN1;
            sel_toggle_cnt <= '0;
        end else begin
            sel_prev <= sel;
            if ((sel != sel_prev) && (sel_toggle_cnt != CNT_MAX)) begin
                sel_toggle_cnt <= sel_toggle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux2_pipe.sv
// tb/tb_mux2_pipe.sv - directed self-checking bench for mux2_pipe (default build)
module tb_mux2_pipe;

    logic       clk;
    logic       rst_n;

    logic       a_sel;
    logic [0:0] a_in1;
    logic [0:0] a_in2;
    logic       a_in_valid;
    logic [0:0] a_out;
    logic [0:0] a_out_q;
    logic       a_out_q_valid;
    logic [7:0] a_cnt;

    logic       b_sel;
    logic [7:0] b_in1;
    logic [7:0] b_in2;
    logic       b_in_valid;
    logic [7:0] b_out;
    logic [7:0] b_out_q;
    logic       b_out_q_valid;
    logic [7:0] b_cnt;

    int errors = 0;
    int checks = 0;

    mux2_pipe #(
        .WIDTH (1),
        .CNT_W (8)
    ) u_w1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .sel            (a_sel),
        .in1            (a_in1),
        .in2            (a_in2),
        .in_valid       (a_in_valid),
        .out            (a_out),
        .out_q          (a_out_q),
        .out_q_valid    (a_out_q_valid),
        .sel_toggle_cnt (a_cnt)
    );

    mux2_pipe #(
        .WIDTH (8),
        .CNT_W (8)
    ) u_w8 (
        .clk            (clk),
        .rst_n          (rst_n),
        .sel            (b_sel),
        .in1            (b_in1),
        .in2            (b_in2),
        .in_valid       (b_in_valid),
        .out            (b_out),
        .out_q          (b_out_q),
        .out_q_valid    (b_out_q_valid),
        .sel_toggle_cnt (b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [2:0] vec [7];
        logic       exp_tt [7];

        vec[0] = 3'b000; exp_tt[0] = 1'b0;
        vec[1] = 3'b010; exp_tt[1] = 1'b1;
        vec[2] = 3'b011; exp_tt[2] = 1'b1;
        vec[3] = 3'b100; exp_tt[3] = 1'b0;
        vec[4] = 3'b110; exp_tt[4] = 1'b0;
        vec[5] = 3'b101; exp_tt[5] = 1'b1;
        vec[6] = 3'b111; exp_tt[6] = 1'b1;

        rst_n      = 1'b0;
        a_sel      = 1'b0;
        a_in1      = 1'b0;
        a_in2      = 1'b0;
        a_in_valid = 1'b0;
        b_sel      = 1'b0;
        b_in1      = 8'h00;
        b_in2      = 8'h00;
        b_in_valid = 1'b0;

        #2;
        check("reset_out_q", 32'(b_out_q), 32'h0);
        check("reset_out_q_valid", 32'(b_out_q_valid), 32'h0);
        check("reset_cnt", 32'(b_cnt), 32'h0);

        // Truth table on the 1-bit instance, held in reset: out needs no clock
        for (int i = 0; i < 7; i++) begin
            a_sel = vec[i][2];
            a_in1 = vec[i][1];
            a_in2 = vec[i][0];
            #1;
            check($sformatf("truth_%03b", vec[i]), 32'(a_out), 32'(exp_tt[i]));
            #9;
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Capture in1 with valid
        @(negedge clk);
        b_in1      = 8'hA5;
        b_in2      = 8'h3C;
        b_sel      = 1'b0;
        b_in_valid = 1'b1;
        #1;
        check("out_sel0_comb", 32'(b_out), 32'hA5);
        @(posedge clk);
        #1;
        check("out_q_sel0", 32'(b_out_q), 32'hA5);
        check("out_q_valid_sel0", 32'(b_out_q_valid), 32'h1);
        check("cnt_no_toggle", 32'(b_cnt), 32'h0);

        // Switch to in2 without valid: out_q must hold
        @(negedge clk);
        b_sel      = 1'b1;
        b_in_valid = 1'b0;
        #1;
        check("out_sel1_comb", 32'(b_out), 32'h3C);
        @(posedge clk);
        #1;
        check("out_q_hold", 32'(b_out_q), 32'hA5);
        check("out_q_valid_low", 32'(b_out_q_valid), 32'h0);
        check("cnt_first_toggle", 32'(b_cnt), 32'h1);

        // Toggle every cycle: 1 + 300 transitions saturates at 255
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            b_sel = ~b_sel;
            @(posedge clk);
            #1;
            if (i == 9) check("cnt_after_11", 32'(b_cnt), 32'd11);
            if (i == 253) check("cnt_reach_max", 32'(b_cnt), 32'd255);
        end
        check("cnt_saturated", 32'(b_cnt), 32'd255);

        // Load out_q with something nonzero before the mid-run reset
        @(negedge clk);
        b_in_valid = 1'b1;
        b_sel      = 1'b0;
        @(posedge clk);
        #1;
        check("out_q_preload", 32'(b_out_q), 32'hA5);
        check("cnt_still_max", 32'(b_cnt), 32'd255);

        // Async reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_q", 32'(b_out_q), 32'h0);
        check("midrst_out_q_valid", 32'(b_out_q_valid), 32'h0);
        check("midrst_cnt", 32'(b_cnt), 32'h0);
        b_sel = 1'b1;
        b_in2 = 8'h96;
        #1;
        check("midrst_out_tracks", 32'(b_out), 32'h96);
        b_sel = 1'b0;
        b_in1 = 8'h5A;
        #1;
        check("midrst_out_tracks2", 32'(b_out), 32'h5A);

        // Recover and capture again
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_out_q", 32'(b_out_q), 32'h5A);
        check("post_rst_valid", 32'(b_out_q_valid), 32'h1);
        check("post_rst_cnt", 32'(b_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
